// File: rtl/branch_metric_unit.sv
// Radix-4 Viterbi branch metric stage: Hamming distance of each trellis entry's
// expected output against the latched received word, plus sweep minimum tracking.
module branch_metric_unit #(
    parameter int MAX_ENTRIES = 256,
    parameter int DIST_W      = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en_bm,
    input  logic                               mode_select,
    input  logic                               rx_load,
    input  logic [5:0]                         rx_word,
    input  logic [$clog2(MAX_ENTRIES+1)-1:0]   entry_count,
    input  logic                               mux_valid,
    input  logic [23:0]                        mux,
    output logic                               bm_valid,
    output logic [1:0]                         bm_in,
    output logic [7:0]                         bm_cur,
    output logic [7:0]                         bm_nxt,
    output logic [DIST_W-1:0]                  bm_dist,
    output logic                               sweep_done,
    output logic [DIST_W-1:0]                  bm_min,
    output logic [9:0]                         bm_min_state
);

    localparam int CNT_W = $clog2(MAX_ENTRIES + 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    typedef struct packed {
        logic [1:0] inb;
        logic [7:0] cur;
        logic [7:0] nxt;
    } br_t;

    state_t             state, state_nxt;
    logic [5:0]         rx_reg;
    logic               mode_reg;
    logic [CNT_W-1:0]   cnt_reg, acc_cnt, out_cnt;
    logic [2:1]         vld_pipe;
    logic [5:0]         s1_x;
    br_t                s1_br;
    logic [DIST_W-1:0]  min_reg;
    logic [9:0]         min_st;
    logic               hold;
    logic               load_ok, take, last_out;
    logic [5:0]         mask;

    function automatic logic [DIST_W-1:0] popcnt(input logic [5:0] x);
        logic [DIST_W-1:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) c = c + DIST_W'(x[i]);
        return c;
    endfunction

    assign load_ok  = en_bm && (state == IDLE) && rx_load && (entry_count != '0);
    assign take     = en_bm && (state == SWEEP) && mux_valid && (acc_cnt < cnt_reg);
    assign last_out = (state == SWEEP) && vld_pipe[2] && ((out_cnt + CNT_W'(1)) == cnt_reg);
    assign mask     = mode_reg ? 6'h3F : 6'h0F;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_bm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_ok)  state_nxt = SWEEP;
                SWEEP:   if (last_out) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_reg   <= '0;
            mode_reg <= 1'b0;
            cnt_reg  <= '0;
            acc_cnt  <= '0;
            out_cnt  <= '0;
            vld_pipe <= '0;
            s1_x     <= '0;
            s1_br    <= '0;
            bm_in    <= '0;
            bm_cur   <= '0;
            bm_nxt   <= '0;
            bm_dist  <= '0;
            min_reg  <= '1;
            min_st   <= '0;
            hold     <= 1'b0;
        end else if (!en_bm) begin
            acc_cnt  <= '0;
            out_cnt  <= '0;
            vld_pipe <= '0;
            s1_x     <= '0;
            s1_br    <= '0;
            bm_in    <= '0;
            bm_cur   <= '0;
            bm_nxt   <= '0;
            bm_dist  <= '0;
            hold     <= 1'b0;
        end else begin
            if (load_ok) begin
                rx_reg   <= rx_word;
                mode_reg <= mode_select;
                cnt_reg  <= entry_count;
                acc_cnt  <= '0;
                out_cnt  <= '0;
                min_reg  <= '1;
                min_st   <= '0;
                hold     <= 1'b0;
            end else if (take) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            // Idle pipeline slots carry zeros so outputs read 0 when not valid
            vld_pipe[1] <= take;
            s1_x        <= take ? ((mux[5:0] ^ rx_reg) & mask) : 6'h00;
            s1_br       <= take ? br_t'(mux[23:6]) : br_t'(18'h0);

            vld_pipe[2] <= vld_pipe[1];
            bm_dist     <= popcnt(s1_x);
            bm_in       <= s1_br.inb;
            bm_cur      <= s1_br.cur;
            bm_nxt      <= s1_br.nxt;

            // Strict compare keeps the earliest branch on ties
            if ((state == SWEEP) && vld_pipe[2]) begin
                out_cnt <= out_cnt + CNT_W'(1);
                if (bm_dist < min_reg) begin
                    min_reg <= bm_dist;
                    min_st  <= {bm_in, bm_cur};
                end
            end

            if (last_out) hold <= 1'b1;
        end
    end

    assign bm_valid     = vld_pipe[2];
    assign sweep_done   = (state == DONE);
    assign bm_min       = hold ? min_reg : '0;
    assign bm_min_state = hold ? min_st  : '0;

endmodule

// File: tb/tb_branch_metric_unit.sv
// Randomized + directed bench for branch_metric_unit against a per-sweep
// behavioural model that schedules expected outputs by cycle.
module tb_branch_metric_unit;

    localparam int DEPTH = 4096;

    typedef struct packed {
        logic       v;
        logic [1:0] i;
        logic [7:0] c;
        logic [7:0] n;
        logic [2:0] d;
    } bm_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_bm = 1'b0, mode_select = 1'b0, rx_load = 1'b0, mux_valid = 1'b0;
    logic [5:0]  rx_word = '0;
    logic [8:0]  entry_count = '0;
    logic [23:0] mux = '0;
    logic        bm_valid, sweep_done;
    logic [1:0]  bm_in;
    logic [7:0]  bm_cur, bm_nxt;
    logic [2:0]  bm_dist, bm_min;
    logic [9:0]  bm_min_state;

    branch_metric_unit dut (
        .clk(clk), .rst(rst), .en_bm(en_bm), .mode_select(mode_select),
        .rx_load(rx_load), .rx_word(rx_word), .entry_count(entry_count),
        .mux_valid(mux_valid), .mux(mux), .bm_valid(bm_valid), .bm_in(bm_in),
        .bm_cur(bm_cur), .bm_nxt(bm_nxt), .bm_dist(bm_dist), .sweep_done(sweep_done),
        .bm_min(bm_min), .bm_min_state(bm_min_state)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_pass = 0;
    int   e = 0;
    int   vcount = 0, dcount = 0;
    bm_t  exp_bm [DEPTH];
    logic exp_done [DEPTH];

    // model state
    bit         busy = 0, hold = 0;
    int         load_edge, free_edge, hold_start, m_cnt, taken;
    logic [5:0] m_rx;
    logic       m_mode;
    logic [2:0] mn, hmin;
    logic [9:0] mst, hst;
    logic [12:0] exp_min_now;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s at edge %0d: got %h expected %h", tag, e, got, expv);
    endtask

    task automatic model_edge();
        int d;
        if (!rst || !en_bm) begin
            busy = 0;
            hold = 0;
            for (int k = e; k < e + 3; k++) begin
                exp_bm[k]   = '0;
                exp_done[k] = 1'b0;
            end
        end else begin
            if (busy && e >= free_edge) busy = 0;
            if (!busy) begin
                if (rx_load && entry_count != 0) begin
                    busy = 1; load_edge = e; free_edge = 1 << 30;
                    m_rx = rx_word; m_mode = mode_select; m_cnt = int'(entry_count);
                    taken = 0; mn = 3'd7; mst = '0; hold = 0;
                end
            end else if (e > load_edge && taken < m_cnt && mux_valid) begin
                d = $countones((mux[5:0] ^ m_rx) & (m_mode ? 6'h3F : 6'h0F));
                exp_bm[e+1] = '{v: 1'b1, i: mux[23:22], c: mux[21:14], n: mux[13:6], d: 3'(d)};
                if (d < int'(mn)) begin
                    mn  = 3'(d);
                    mst = mux[23:14];
                end
                taken++;
                if (taken == m_cnt) begin
                    exp_done[e+2] = 1'b1;
                    free_edge  = e + 4;
                    hold       = 1;
                    hold_start = e + 2;
                    hmin = mn;
                    hst  = mst;
                end
            end
        end
        exp_min_now = (hold && e >= hold_start) ? {hmin, hst} : 13'h0;
    endtask

    task automatic drive(input logic en, input logic ld, input logic [5:0] rw,
                         input logic [8:0] ec, input logic md, input logic mv,
                         input logic [23:0] mx);
        en_bm = en; rx_load = ld; rx_word = rw; entry_count = ec;
        mode_select = md; mux_valid = mv; mux = mx;
        e++;
        model_edge();
        @(posedge clk);
        #1;
        chk("bm", 32'({bm_valid, bm_in, bm_cur, bm_nxt, bm_dist}), 32'(exp_bm[e]));
        chk("done", 32'(sweep_done), 32'(exp_done[e]));
        chk("min", 32'({bm_min, bm_min_state}), 32'(exp_min_now));
        if (bm_valid) vcount++;
        if (sweep_done) dcount++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b1, 1'b0, 6'($urandom), 9'($urandom), 1'($urandom),
                  1'($urandom), 24'($urandom));
    endtask

    task automatic load(input logic [5:0] rw, input logic [8:0] ec, input logic md);
        drive(1'b1, 1'b1, rw, ec, md, 1'b0, 24'($urandom));
    endtask

    task automatic ent(input logic [5:0] o);
        logic [17:0] f;
        f = 18'($urandom);
        drive(1'b1, 1'b0, 6'($urandom), 9'($urandom), 1'($urandom), 1'b1, {f, o});
    endtask

    task automatic gap();
        drive(1'b1, 1'b0, 6'($urandom), 9'($urandom), 1'($urandom), 1'b0, 24'($urandom));
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            exp_bm[k]   = '0;
            exp_done[k] = 1'b0;
        end

        // reset with enable high and random inputs
        for (int k = 0; k < 3; k++)
            drive(1'b1, 1'($urandom), 6'($urandom), 9'($urandom), 1'($urandom),
                  1'($urandom), 24'($urandom));
        rst = 1'b1;
        for (int k = 0; k < 4; k++)
            drive(1'b1, 1'b0, 6'($urandom), 9'($urandom), 1'($urandom),
                  1'($urandom), 24'($urandom));

        // rate 1/3 distances 0,6,1,4
        load(6'b101101, 9'd4, 1'b1);
        ent(6'b101101); ent(6'b010010); ent(6'b101100); ent(6'b000000);
        idle(5);

        // rate 1/2 ignores bits 5:4
        load(6'b110101, 9'd2, 1'b0);
        ent(6'b000101); ent(6'b111010);
        idle(5);

        // excess entries dropped; rx_load mid-sweep ignored
        vcount = 0; dcount = 0;
        load(6'($urandom), 9'd2, 1'b1);
        ent(6'($urandom));
        drive(1'b1, 1'b1, 6'($urandom), 9'd5, 1'b1, 1'b1, 24'($urandom));
        ent(6'($urandom)); ent(6'($urandom)); ent(6'($urandom));
        idle(5);
        chk("t4_pulses", 32'(vcount), 32'd2);
        chk("t4_done", 32'(dcount), 32'd1);

        // tie keeps earliest branch; gapped input
        load(6'b000000, 9'd4, 1'b1);
        ent(6'b000011); gap(); ent(6'b000001); ent(6'b000010); gap(); gap(); ent(6'b000111);
        idle(5);

        // abandon mid-sweep, then a zero-count load is ignored
        load(6'($urandom), 9'd5, 1'b1);
        ent(6'($urandom)); ent(6'($urandom));
        drive(1'b0, 1'b0, 6'($urandom), 9'($urandom), 1'b0, 1'b1, 24'($urandom));
        drive(1'b1, 1'b1, 6'($urandom), 9'd0, 1'b1, 1'b1, 24'($urandom));
        for (int k = 0; k < 4; k++) ent(6'($urandom));
        idle(2);

        // full 256-entry sweep
        vcount = 0; dcount = 0;
        load(6'($urandom), 9'd256, 1'($urandom));
        for (int k = 0; k < 256; k++) ent(6'($urandom));
        idle(5);
        chk("t6_pulses", 32'(vcount), 32'd256);
        chk("t6_done", 32'(dcount), 32'd1);

        // random sweeps with gaps, stray loads and occasional enable drops
        for (int s = 0; s < 30; s++) begin
            int n;
            n = int'($urandom_range(1, 12));
            load(6'($urandom), 9'(n), 1'($urandom));
            for (int k = 0; k < 2 * n + 6; k++) begin
                drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                      6'($urandom), 9'($urandom_range(0, 12)), 1'($urandom),
                      ($urandom_range(0, 9) < 7), 24'($urandom));
            end
            idle(4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
